// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load-size encodings, datapath widths and the
// MEM/WB control bundle.
package cpu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RBITS = 5;

  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;

  typedef struct packed {
    logic       RegWrite;
    logic       MemToReg;
    logic [1:0] ld_size;
    logic       ld_unsigned;
  } mem_wb_ctrl_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load formatter: picks the addressed little-endian lane,
// extends it, and flags misaligned half/word accesses.
module load_align
  import cpu_pkg::*;
#(
  parameter int unsigned W = cpu_pkg::XLEN
) (
  input  logic [W-1:0] mem_data,
  input  logic [1:0]   addr,
  input  logic [1:0]   size,
  input  logic         is_unsigned,
  output logic [W-1:0] data,
  output logic         misalign
);

  logic [W-1:0] shifted;
  logic [7:0]   byte_val;
  logic [15:0]  half_val;

  assign shifted = mem_data >> {addr, 3'b000};

  // Lane selection and extension; reserved size 11 behaves as a word.
  always_comb begin
    byte_val = shifted[7:0];
    half_val = 16'h0000;
    data     = mem_data;
    misalign = 1'b0;
    if (addr[1]) begin
      half_val = mem_data[31:16];
    end else begin
      half_val = mem_data[15:0];
    end
    case (size)
      LD_B: begin
        if (is_unsigned) begin
          data = {{(W-8){1'b0}}, byte_val};
        end else begin
          data = {{(W-8){byte_val[7]}}, byte_val};
        end
        misalign = 1'b0;
      end
      LD_H: begin
        if (is_unsigned) begin
          data = {{(W-16){1'b0}}, half_val};
        end else begin
          data = {{(W-16){half_val[15]}}, half_val};
        end
        misalign = addr[0];
      end
      default: begin
        data     = mem_data;
        misalign = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats loads, selects the write-back value and
// counts retired instructions. All outputs are registered.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = cpu_pkg::XLEN,
  parameter int unsigned RBITS = cpu_pkg::RBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  memOut,
  input  logic [XLEN-1:0]  exeOut,
  input  logic [RBITS-1:0] rd_in,
  input  logic             valid_in,
  input  logic             RegWrite_in,
  input  logic             MemToReg_in,
  input  logic [1:0]       ld_size,
  input  logic             ld_unsigned,
  input  logic             stall,
  input  logic             flush,
  output logic [XLEN-1:0]  wb_data,
  output logic [RBITS-1:0] wb_rd,
  output logic             wb_RegWrite,
  output logic             wb_valid,
  output logic             wb_misalign,
  output logic [31:0]      wb_count
);

  mem_wb_ctrl_t    ctrl;
  logic [XLEN-1:0] aligned;
  logic            lane_misalign;
  logic            misalign;
  logic [XLEN-1:0] next_data;
  logic            next_we;

  assign ctrl = '{RegWrite: RegWrite_in, MemToReg: MemToReg_in,
                  ld_size: ld_size, ld_unsigned: ld_unsigned};

  load_align #(.W(XLEN)) u_align (
    .mem_data    (memOut),
    .addr        (exeOut[1:0]),
    .size        (ctrl.ld_size),
    .is_unsigned (ctrl.ld_unsigned),
    .data        (aligned),
    .misalign    (lane_misalign)
  );

  // Next-state values; a misaligned load keeps the raw memory word.
  always_comb begin
    misalign = ctrl.MemToReg & lane_misalign;
    if (!ctrl.MemToReg) begin
      next_data = exeOut;
    end else if (misalign) begin
      next_data = memOut;
    end else begin
      next_data = aligned;
    end
    next_we = valid_in & ctrl.RegWrite & (rd_in != {RBITS{1'b0}}) & ~misalign;
  end

  // Pipeline register update: reset > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data     <= {XLEN{1'b0}};
      wb_rd       <= {RBITS{1'b0}};
      wb_RegWrite <= 1'b0;
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
      wb_count    <= 32'd0;
    end else if (flush) begin
      wb_data     <= {XLEN{1'b0}};
      wb_rd       <= {RBITS{1'b0}};
      wb_RegWrite <= 1'b0;
      wb_valid    <= 1'b0;
      wb_misalign <= 1'b0;
    end else if (stall) begin
      wb_data     <= wb_data;
      wb_rd       <= wb_rd;
      wb_RegWrite <= wb_RegWrite;
      wb_valid    <= wb_valid;
      wb_misalign <= wb_misalign;
    end else begin
      wb_data     <= next_data;
      wb_rd       <= rd_in;
      wb_RegWrite <= next_we;
      wb_valid    <= valid_in;
      wb_misalign <= valid_in & misalign;
      if (valid_in && !misalign) begin
        wb_count <= wb_count + 32'd1;
      end else begin
        wb_count <= wb_count;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected outputs are queued as stimulus
// is driven and compared one cycle later.
module tb_mem_wb_stage;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        valid;
    logic        mis;
    logic [31:0] count;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memOut = 32'd0;
  logic [31:0] exeOut = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        valid_in = 1'b0;
  logic        RegWrite_in = 1'b0;
  logic        MemToReg_in = 1'b0;
  logic [1:0]  ld_size = 2'b00;
  logic        ld_unsigned = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite;
  logic        wb_valid;
  logic        wb_misalign;
  logic [31:0] wb_count;

  int   errors = 0;
  int   checks = 0;
  out_t sb[$];
  out_t last_exp = '0;
  logic [31:0] mcount = 32'd0;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .memOut(memOut), .exeOut(exeOut), .rd_in(rd_in),
    .valid_in(valid_in), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .stall(stall), .flush(flush),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
    .wb_valid(wb_valid), .wb_misalign(wb_misalign), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t observed();
    return '{data: wb_data, rd: wb_rd, we: wb_RegWrite, valid: wb_valid,
             mis: wb_misalign, count: wb_count};
  endfunction

  // Drive one cycle, push the model's expectation, wait past the edge.
  task automatic cycle(input logic [31:0] m, input logic [31:0] e, input logic [4:0] rd,
                       input logic v, input logic rw, input logic m2r,
                       input logic [1:0] sz, input logic un,
                       input logic st, input logic fl, input logic rs);
    out_t        x;
    logic [31:0] sh;
    logic [15:0] hv;
    logic [31:0] val;
    logic        mis;
    @(negedge clk);
    memOut = m; exeOut = e; rd_in = rd; valid_in = v; RegWrite_in = rw;
    MemToReg_in = m2r; ld_size = sz; ld_unsigned = un;
    stall = st; flush = fl; reset = rs;
    x = '0;
    if (rs) begin
      mcount = 32'd0;
    end else if (fl) begin
      x.count = mcount;
    end else if (st) begin
      x = last_exp;
    end else begin
      sh = m >> (8 * e[1:0]);
      hv = (e[1] == 1'b1) ? m[31:16] : m[15:0];
      if (sz == 2'b00) begin
        val = un ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        mis = 1'b0;
      end else if (sz == 2'b01) begin
        val = un ? {16'd0, hv} : {{16{hv[15]}}, hv};
        mis = e[0];
      end else begin
        val = m;
        mis = (e[1:0] != 2'b00);
      end
      mis     = mis & m2r;
      x.data  = !m2r ? e : (mis ? m : val);
      x.rd    = rd;
      x.we    = v & rw & (rd != 5'd0) & !mis;
      x.valid = v;
      x.mis   = v & mis;
      if (v && !mis) mcount = mcount + 32'd1;
      x.count = mcount;
    end
    last_exp = x;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e, g;
    cycle(32'hDEAD_BEEF, 32'h0000_0004, 5'd7, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); g = observed(); checks++;
    if (g !== e || g !== '0) begin
      errors++; $display("FAIL reset: got %h expected %h", g, e);
    end
  endtask

  task automatic test_alu();
    out_t e, g;
    cycle(32'hFFFF_FFFF, 32'h0000_1234, 5'd5, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); g = observed(); checks++;
    if (g !== e) begin
      errors++; $display("FAIL alu_op: got %h expected %h", g, e);
    end
  endtask

  task automatic test_loads();
    logic [31:0] mem_t[8] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h8001_7FFF,
                              32'h8001_7FFF, 32'h1234_5678, 32'h1234_5678, 32'hCAFE_F00D};
    logic [31:0] adr_t[8] = '{32'h100_0001, 32'h100_0002, 32'h100_0003, 32'h200_0002,
                              32'h200_0001, 32'h300_0000, 32'h300_0002, 32'h400_0001};
    logic [1:0]  sz_t[8]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
    logic        un_t[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    out_t e, g;
    for (int i = 0; i < 8; i++) begin
      cycle(mem_t[i], adr_t[i], 5'(i + 3), 1'b1, 1'b1, 1'b1, sz_t[i], un_t[i], 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL load_%0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_rd_zero_and_bubble();
    out_t e, g;
    for (int i = 0; i < 2; i++) begin
      cycle(32'h0, 32'h0000_0042, (i == 0) ? 5'd0 : 5'd9, (i == 0), 1'b1, 1'b0,
            2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL rd0_bubble_%0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_stall();
    out_t e, g;
    for (int i = 0; i < 5; i++) begin
      cycle(32'h0, 32'h0000_0A00 + 32'(i), 5'(10 + i), 1'b1, 1'b1, 1'b0, 2'b10, 1'b0,
            (i >= 1 && i <= 3), 1'b0, 1'b0);
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL stall_%0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_flush_stall();
    out_t e, g;
    cycle(32'h0, 32'h0000_0777, 5'd12, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    e = sb.pop_front(); g = observed(); checks++;
    if (g !== e || wb_valid !== 1'b0 || wb_RegWrite !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %h expected %h", g, e);
    end
  endtask

  task automatic test_wrap_and_reset_mid_stall();
    out_t e, g;
    @(negedge clk);
    force dut.wb_count = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count;
    mcount = 32'hFFFF_FFFF;
    last_exp.count = mcount;
    for (int i = 0; i < 3; i++) begin
      cycle(32'h0, 32'h0000_0055, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0,
            (i >= 1), 1'b0, (i == 2));
      e = sb.pop_front(); g = observed(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL wrap_reset_%0d: got %h expected %h", i, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_rd_zero_and_bubble();
    test_stall();
    test_flush_stall();
    test_wrap_and_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and load-formatting stage of the pipelined CPU. It sits directly downstream of the data-memory stage. Each cycle it captures that stage's read data (`memOut`) and ALU result/address (`exeOut`), plus the destination register and write-back controls. Loads are extracted and sign- or zero-extended, the write-back value is selected, and a registered result is presented to the register file and the forwarding unit one cycle later.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `RBITS`, 5, register-index width

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `memOut`  in  XLEN  read data from the data-memory stage; valid in the same cycle as `exeOut`
- `exeOut`  in  XLEN  ALU result, which is also the memory address
- `rd_in`  in  RBITS  destination register
- `valid_in`  in  1  an instruction occupies the MEM stage
- `RegWrite_in`  in  1  instruction writes the register file
- `MemToReg_in`  in  1  write-back source: 1 = load data, 0 = `exeOut`
- `ld_size`  in  2  load width: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
- `ld_unsigned`  in  1  zero-extend instead of sign-extend
- `stall`  in  1  hold the current contents
- `flush`  in  1  replace the captured instruction with a bubble
- `wb_data`  out  XLEN  write-back value
- `wb_rd`  out  RBITS  write-back register
- `wb_RegWrite`  out  1  register-file write enable
- `wb_valid`  out  1  slot holds a real instruction
- `wb_misalign`  out  1  the captured load was misaligned
- `wb_count`  out  32  count of retired instructions

## Operation
- Byte order is little-endian: byte lane k is `memOut[8k+7:8k]`, with k = `exeOut[1:0]`.
- Byte load: selects lane k, then extends.
- Half load: selects lane `exeOut[1]`×2 (16 bits), then extends. It is misaligned if `exeOut[0]`=1.
- Word load: passes `memOut` through unchanged. It is misaligned if `exeOut[1:0]`≠0.
- Misalignment is evaluated only when `MemToReg_in`=1.
- Next `wb_data` = `MemToReg_in` ? aligned load value : `exeOut`. On misalignment the raw `memOut` is captured.
- Next `wb_RegWrite` = `valid_in` & `RegWrite_in` & (`rd_in`≠0) & !misalign.
- Next `wb_misalign` = `valid_in` & misalign.
- Update priority on each rising edge, highest first:
  1. `reset`: all outputs cleared to 0, including `wb_count`.
  2. `flush`: `wb_valid`, `wb_RegWrite` and `wb_misalign` set to 0; `wb_data` and `wb_rd` set to 0; `wb_count` unchanged.
  3. `stall`: every register holds; `wb_count` unchanged.
  4. Otherwise: capture as described above.
- `wb_count` increments, wrapping from 0xFFFF_FFFF to 0, only on a capture (case 4) with `valid_in`=1 and no misalignment.
- Capture with `valid_in`=0 produces a bubble: valid, RegWrite and misalign are 0; data and rd are still captured.
- `flush` and `stall` asserted together: the flush wins.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset value of every output is 0. Reset asserted mid-stall or mid-flush still clears everything on that edge.
- A stall held for M cycles keeps the outputs constant for M cycles; the instruction presented on the first un-stalled edge is then captured.
- `wb_data` and `wb_rd` are consumed by the forwarding unit in the same cycle they are output.

## Structure
- Shared package `cpu_pkg` holds:
  - the `ld_size` encodings `LD_B`, `LD_H`, `LD_W`;
  - `XLEN` and `RBITS`;
  - a packed struct `mem_wb_ctrl_t` {RegWrite, MemToReg, ld_size, ld_unsigned}.
- Sub-module `load_align` is purely combinational. It takes `memOut`, `exeOut[1:0]`, `ld_size` and `ld_unsigned`, and returns the aligned data and the misalign flag.
- Pipeline registers and the counter live in `mem_wb_stage`.

## Test plan
- Reset then idle:
  - After `reset` the outputs are all 0.
  - One ALU op (`MemToReg_in`=0, `exeOut`=0x0000_1234, `rd_in`=5) gives `wb_data`=0x1234, `wb_rd`=5, `wb_RegWrite`=1, `wb_count`=1 one cycle later.
- Byte loads with `memOut`=0x80FF_7F01:
  - `exeOut`=…1, signed: `wb_data`=0x0000_007F.
  - `exeOut`=…2, signed: `wb_data`=0xFFFF_FFFF.
  - `exeOut`=…3, unsigned: `wb_data`=0x0000_0080.
- Half loads with `memOut`=0x8001_7FFF:
  - `exeOut`=…2, signed: `wb_data`=0xFFFF_8001.
  - `exeOut`=…1: `wb_misalign`=1, `wb_RegWrite`=0, `wb_count` unchanged.
- `rd_in`=0 with `RegWrite_in`=1: `wb_RegWrite`=0, `wb_valid`=1, `wb_count` increments.
- Stall and flush:
  - `stall` held 3 cycles: outputs frozen and `wb_count` constant.
  - `flush`+`stall` together: bubble, with `wb_valid`=0 and `wb_RegWrite`=0.
- Counter wrap and reset mid-stall:
  - Preload to 0xFFFF_FFFF via 2^32−1 captures, or force in simulation; one more valid capture gives `wb_count`=0.
  - `reset` asserted during a stall clears all outputs on that edge.
